apb_mem_slave: RTL and testbench

- Parametrised, clocked APB slave memory: the next generation of the combinational storage block.
- Implements the full APB setup/access handshake with programmable wait states, byte strobes, `pslverr` on bad addresses, and registered read data.
- Sits behind the APB bridge/decoder as a generic on-chip RAM target.
- One instance per memory region; the decoder drives `psel`.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_mem_array.sv | 49 ++++
 rtl/apb_mem_slave.sv | 158 +++++++++++++++
 tb/tb_apb_mem_slave.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and sizing helpers for the APB memory slave
//
// Contents:
//   apb_state_e   : transfer FSM states (IDLE / ACCESS / DONE)
//   APB_STRB_W    : number of byte-lane strobes for a given data width
//   apb_addr_lsb  : count of byte-offset bits below the word index in paddr
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } apb_state_e;

    function automatic int APB_STRB_W(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int apb_addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - single-port synchronous RAM with byte write enables
//
// Ports:
//   i_clk    : clock, all activity on the rising edge
//   i_en     : access enable; nothing happens when low
//   i_we     : 1 = write the enabled byte lanes, 0 = read
//   i_be     : per-byte write enables
//   i_addr   : word address
//   i_wdata  : write data
//   o_rdata  : registered read data, updated only by an enabled read
module apb_mem_array
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int AW         = 8
) (
    input  logic                              i_clk,
    input  logic                              i_en,
    input  logic                              i_we,
    input  logic [APB_STRB_W(DATA_WIDTH)-1:0] i_be,
    input  logic [AW-1:0]                     i_addr,
    input  logic [DATA_WIDTH-1:0]             i_wdata,
    output logic [DATA_WIDTH-1:0]             o_rdata
);

    localparam int NB = APB_STRB_W(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Contents are deliberately not reset so the array maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < NB; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB RAM target with wait states, byte strobes and error response
//
// Ports:
//   pclk, preset        : clock and synchronous active-high reset
//   psel, penable       : APB select and access-phase indicator
//   pwrite              : 1 = write, 0 = read
//   paddr               : byte address, word index taken above the byte-offset bits
//   pwdata, pstrb       : write data and byte-lane strobes, sampled at setup
//   prdata              : read data, valid while pready is high on a read
//   pready              : registered one-cycle transfer-complete strobe
//   pslverr             : error response, only asserted together with pready
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH          = 256,
    parameter int WAIT_STATES    = 0,
    parameter int STRB_ZERO_FULL = 1
) (
    input  logic                              pclk,
    input  logic                              preset,
    input  logic                              psel,
    input  logic                              penable,
    input  logic                              pwrite,
    input  logic [ADDR_WIDTH-1:0]             paddr,
    input  logic [DATA_WIDTH-1:0]             pwdata,
    input  logic [APB_STRB_W(DATA_WIDTH)-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]             prdata,
    output logic                              pready,
    output logic                              pslverr
);

    localparam int STRB_W = APB_STRB_W(DATA_WIDTH);
    localparam int LSB    = apb_addr_lsb(DATA_WIDTH);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_e            r_state;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [MEM_AW-1:0]     r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_strb;
    logic                  r_err;
    logic                  r_pready;
    logic                  r_pslverr;
    logic                  r_rd_valid;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_misalign;
    logic                  w_oob;
    logic                  w_setup;
    logic                  w_live;
    logic                  w_fire;
    logic                  w_commit;
    logic                  w_cur_write;
    logic                  w_cur_err;
    logic [MEM_AW-1:0]     w_cur_addr;
    logic [DATA_WIDTH-1:0] w_cur_wdata;
    logic [STRB_W-1:0]     w_cur_strb;
    logic [STRB_W-1:0]     w_cur_be;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // Address decode on the live bus; only meaningful during the setup phase.
    assign w_idx      = paddr[ADDR_WIDTH-1:LSB];
    assign w_misalign = |(paddr & ADDR_WIDTH'(STRB_W - 1));
    assign w_oob      = (w_idx >= IDX_W'(DEPTH));
    assign w_setup    = psel & ~penable;

    // With zero wait states pready must already be high in the first access
    // cycle, so the commit edge is the setup edge itself and the transfer
    // attributes come straight off the bus. Otherwise they come from the
    // copy captured at setup, which also makes later pwdata/pstrb changes moot.
    assign w_live      = (r_state == ST_IDLE);
    assign w_cur_write = w_live ? pwrite                  : r_write;
    assign w_cur_err   = w_live ? (w_misalign | w_oob)    : r_err;
    assign w_cur_addr  = w_live ? w_idx[MEM_AW-1:0]       : r_addr;
    assign w_cur_wdata = w_live ? pwdata                  : r_wdata;
    assign w_cur_strb  = w_live ? pstrb                   : r_strb;

    assign w_cur_be = ((w_cur_strb == '0) && (STRB_ZERO_FULL != 0)) ? {STRB_W{1'b1}} : w_cur_strb;

    // r_cnt holds the access cycles still to elapse before pready; pready is
    // registered, so the completing edge is the one where a single cycle remains.
    assign w_fire = ((r_state == ST_IDLE)   && w_setup && (WAIT_STATES == 0)) ||
                    ((r_state == ST_ACCESS) && psel    && (r_cnt == 4'd1));

    // Reset wins over a completing edge so an interrupted write never lands.
    assign w_commit = w_fire & ~preset & ~w_cur_err;

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (MEM_AW)
    ) u_mem (
        .i_clk   (pclk),
        .i_en    (w_commit),
        .i_we    (w_cur_write),
        .i_be    (w_cur_be),
        .i_addr  (w_cur_addr),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_pready  <= w_fire;
            r_pslverr <= w_fire & w_cur_err;
            if (w_fire) begin
                r_rd_valid <= ~w_cur_write & ~w_cur_err;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_write <= pwrite;
                        r_addr  <= w_idx[MEM_AW-1:0];
                        r_wdata <= pwdata;
                        r_strb  <= pstrb;
                        r_err   <= w_misalign | w_oob;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= (WAIT_STATES == 0) ? ST_DONE : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!psel) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The RAM read register holds its last read; r_rd_valid forces zero after
    // reset and after writes or erroring transfers.
    assign prdata  = r_rd_valid ? w_ram_rdata : '0;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - scoreboard bench for apb_mem_slave across wait-state and strobe modes
module tb_apb_mem_slave;

    localparam int DEPTH = 256;

    logic        pclk = 1'b0;
    logic        preset;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata_v [3];
    logic [2:0]  pready_v;
    logic [2:0]  pslverr_v;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] model [3][DEPTH];
    logic [32:0] exp_q [$];

    always #5 pclk = ~pclk;

    // Instance 0: zero wait, legacy strobe; 1: three waits, APB4 strobe; 2: two waits, legacy.
    apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0), .STRB_ZERO_FULL(1)) u_dut0 (
        .pclk(pclk), .preset(preset), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]));

    apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3), .STRB_ZERO_FULL(0)) u_dut1 (
        .pclk(pclk), .preset(preset), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]));

    apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(2), .STRB_ZERO_FULL(1)) u_dut2 (
        .pclk(pclk), .preset(preset), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]));

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic bit szf_of(input int d);
        return (d != 1);
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        psel_v  = 3'b000;
        penable = 1'b0;
    endtask

    // One full APB transfer on instance d, with the expected response pushed
    // before driving and popped when that instance raises pready.
    task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        logic        err;
        int          idx;
        logic [31:0] exp_rd;
        logic [32:0] e;
        int          cyc;
        bit          seen;

        idx    = int'(addr >> 2);
        err    = (addr[1:0] != 2'b00) || (idx >= DEPTH);
        exp_rd = 32'h0;
        if (!err) begin
            if (wr) begin
                if (strb == 4'h0 && szf_of(d)) begin
                    model[d][idx] = data;
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) model[d][idx][b*8 +: 8] = data[b*8 +: 8];
                    end
                end
            end else begin
                exp_rd = model[d][idx];
            end
        end
        exp_q.push_back({err, exp_rd});

        @(posedge pclk); #1;
        psel_v[d] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pwdata    = data;
        pstrb     = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        pwdata  = ~data;
        pstrb   = ~strb;

        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge pclk);
            cyc++;
            if (pready_v[d]) seen = 1'b1;
            else check_val("pslverr_wait", 64'(pslverr_v[d]), 64'd0);
        end
        check_val("pready_seen", 64'(seen), 64'd1);
        e = exp_q.pop_front();
        if (seen) begin
            check_val("latency", 64'(cyc), 64'(ws_of(d) + 1));
            check_val("prdata", 64'(prdata_v[d]), 64'(e[31:0]));
            check_val("pslverr", 64'(pslverr_v[d]), 64'(e[32]));
        end

        @(posedge pclk); #1;
        bus_idle();
        @(negedge pclk);
        check_val("pready_pulse", 64'(pready_v[d]), 64'd0);
        check_val("pslverr_after", 64'(pslverr_v[d]), 64'd0);
    endtask

    task automatic watch_quiet(input int d, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge pclk);
            check_val(tag, 64'(pready_v[d]), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1'b1;
        bus_idle();
        pwrite = 1'b0;
        paddr  = 32'h0;
        pwdata = 32'h0;
        pstrb  = 4'h0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        for (int d = 0; d < 3; d++) begin
            check_val("rst_pready", 64'(pready_v[d]), 64'd0);
            check_val("rst_pslverr", 64'(pslverr_v[d]), 64'd0);
            check_val("rst_prdata", 64'(prdata_v[d]), 64'd0);
        end
        @(posedge pclk); #1;
        preset = 1'b0;

        // Zero-wait write/read, partial strobes, zero strobe in legacy mode.
        apb_xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        apb_xfer(0, 0, 32'h10, 32'h0, 4'h0);
        apb_xfer(0, 1, 32'h20, 32'h11223344, 4'hF);
        apb_xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'h5);
        apb_xfer(0, 0, 32'h20, 32'h0, 4'h0);
        check_val("strb_model", 64'(model[0][8]), 64'h11BB33DD);
        apb_xfer(0, 1, 32'h30, 32'hCAFEF00D, 4'hF);
        apb_xfer(0, 1, 32'h30, 32'h12345678, 4'h0);
        apb_xfer(0, 0, 32'h30, 32'h0, 4'h0);

        // Error responses leave memory intact and return zero data.
        apb_xfer(0, 1, 32'h0, 32'h00C0FFEE, 4'hF);
        apb_xfer(0, 1, 32'h400, 32'h55555555, 4'hF);
        apb_xfer(0, 0, 32'h0, 32'h0, 4'h0);
        apb_xfer(0, 0, 32'h13, 32'h0, 4'h0);
        apb_xfer(0, 1, 32'h12, 32'h66666666, 4'hF);
        apb_xfer(0, 0, 32'h10, 32'h0, 4'h0);
        apb_xfer(0, 0, 32'h3FC, 32'h0, 4'h0);

        // Three wait states, APB4 strobe handling.
        apb_xfer(1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        apb_xfer(1, 0, 32'h10, 32'h0, 4'h0);
        apb_xfer(1, 1, 32'h30, 32'hCAFEF00D, 4'hF);
        apb_xfer(1, 1, 32'h30, 32'h12345678, 4'h0);
        apb_xfer(1, 0, 32'h30, 32'h0, 4'h0);
        apb_xfer(1, 0, 32'h13, 32'h0, 4'h0);

        // psel dropped during wait states on the two-wait instance.
        apb_xfer(2, 1, 32'h40, 32'h01020304, 4'hF);
        @(posedge pclk); #1;
        psel_v[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h40; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check_val("abort_wait", 64'(pready_v[2]), 64'd0);
        @(posedge pclk); #1;
        bus_idle();
        watch_quiet(2, 4, "abort_quiet");
        apb_xfer(2, 0, 32'h40, 32'h0, 4'h0);
        apb_xfer(2, 1, 32'h44, 32'h0A0B0C0D, 4'hF);
        apb_xfer(2, 0, 32'h44, 32'h0, 4'h0);

        // Reset pulsed while instance 1 is in its access phase.
        @(posedge pclk); #1;
        psel_v[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check_val("rstmid_wait", 64'(pready_v[1]), 64'd0);
        @(posedge pclk); #1;
        preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0;
        bus_idle();
        @(negedge pclk);
        check_val("rstmid_prdata", 64'(prdata_v[1]), 64'd0);
        check_val("rstmid_pslverr", 64'(pslverr_v[1]), 64'd0);
        watch_quiet(1, 5, "rstmid_quiet");
        apb_xfer(1, 0, 32'h10, 32'h0, 4'h0);

        // Randomised traffic on the zero-wait instance over a fully written window.
        for (int i = 0; i < 16; i++) begin
            apb_xfer(0, 1, 32'h100 + 32'(i * 4), $urandom, 4'hF);
        end
        for (int i = 0; i < 24; i++) begin
            int          w;
            logic [31:0] a;
            w = int'($urandom_range(0, 1));
            a = 32'h100 + 32'($urandom_range(0, 15) * 4);
            apb_xfer(0, w[0], a, $urandom, 4'($urandom_range(0, 15)));
        end

        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
